// File: rtl/lut_cordic_pkg.sv
// Shared definitions for the hyperbolic CORDIC vectoring datapath:
// FSM states, repeat indices and Q2.(WIDTH-2) format constants.
package lut_cordic_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned FRAC_BITS = WIDTH_DEF - 2;
  localparam int unsigned IDX_W     = 6;
  localparam int unsigned ADR_W     = 5;
  localparam int unsigned REP_IDX_A = 4;
  localparam int unsigned REP_IDX_B = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FETCH,
    ST_ITER,
    ST_DONE
  } state_e;

  // Hyperbolic CORDIC only converges if these indices are executed twice.
  function automatic logic is_repeat_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(REP_IDX_A)) || (idx == IDX_W'(REP_IDX_B));
  endfunction

endpackage

// File: rtl/hyp_cordic_stage.sv
// One hyperbolic CORDIC micro-rotation: shift/add/sub of x, y and z.
module hyp_cordic_stage
  import lut_cordic_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [WIDTH-1:0] z_i,
  input  logic [WIDTH-1:0] rom_i,
  input  logic [IDX_W-1:0] shift_i,
  input  logic             sigma_pos_i,
  output logic [WIDTH-1:0] x_c,
  output logic [WIDTH-1:0] y_c,
  output logic [WIDTH-1:0] z_c
);

  logic signed [WIDTH-1:0] x_sh;
  logic signed [WIDTH-1:0] y_sh;

  // Both cross terms use the incoming x and y; sums wrap modulo 2^WIDTH.
  always_comb begin
    x_sh = $signed(x_i) >>> shift_i;
    y_sh = $signed(y_i) >>> shift_i;
    if (sigma_pos_i) begin
      x_c = x_i + y_sh;
      y_c = y_i + x_sh;
      z_c = z_i - rom_i;
    end else begin
      x_c = x_i - y_sh;
      y_c = y_i - x_sh;
      z_c = z_i + rom_i;
    end
  end

endmodule

// File: rtl/hyp_cordic_vectoring_unit.sv
// Iterative hyperbolic CORDIC in vectoring mode: Z = atanh(Y/X), reading
// one arctanh constant per iteration from an external synchronous ROM.
module hyp_cordic_vectoring_unit
  import lut_cordic_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned ITER  = 24
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BEG_FSM,
  input  logic             ACK_FSM,
  input  logic [WIDTH-1:0] X_IN,
  input  logic [WIDTH-1:0] Y_IN,
  input  logic [WIDTH-1:0] O_D,
  output logic             EN_ROM1,
  output logic [ADR_W-1:0] ADRS,
  output logic [WIDTH-1:0] Z_OUT,
  output logic [WIDTH-1:0] X_OUT,
  output logic             RDY
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic             rep_q, rep_d;
  logic             en_rom_q, en_rom_d;
  logic [ADR_W-1:0] adrs_q, adrs_d;
  logic [WIDTH-1:0] z_out_q, z_out_d;
  logic [WIDTH-1:0] x_out_q, x_out_d;
  logic             rdy_q, rdy_d;

  logic [WIDTH-1:0] x_c, y_c, z_c;
  logic             rep_take_c;
  logic [IDX_W-1:0] i_nxt_c;

  hyp_cordic_stage #(
    .WIDTH(WIDTH)
  ) u_stage (
    .x_i        (x_q),
    .y_i        (y_q),
    .z_i        (z_q),
    .rom_i      (O_D),
    .shift_i    (i_q),
    .sigma_pos_i(y_q[WIDTH-1]),
    .x_c        (x_c),
    .y_c        (y_c),
    .z_c        (z_c)
  );

  assign rep_take_c = is_repeat_idx(i_q) && !rep_q;
  assign i_nxt_c    = rep_take_c ? i_q : i_q + IDX_W'(1);

  // Next-state and output logic; EN_ROM1/ADRS are set on the edge entering FETCH.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    i_d      = i_q;
    rep_d    = rep_q;
    en_rom_d = 1'b0;
    adrs_d   = adrs_q;
    z_out_d  = z_out_q;
    x_out_d  = x_out_q;
    rdy_d    = rdy_q;
    case (state_q)
      ST_IDLE: begin
        if (BEG_FSM) begin
          state_d = ST_LOAD;
          x_d     = X_IN;
          y_d     = Y_IN;
          z_d     = '0;
          i_d     = IDX_W'(1);
          rep_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        state_d  = ST_FETCH;
        en_rom_d = 1'b1;
        adrs_d   = ADR_W'(i_q - IDX_W'(1));
      end
      ST_FETCH: begin
        state_d = ST_ITER;
      end
      ST_ITER: begin
        x_d   = x_c;
        y_d   = y_c;
        z_d   = z_c;
        rep_d = rep_take_c;
        i_d   = i_nxt_c;
        if ((i_q == IDX_W'(ITER)) && !rep_take_c) begin
          state_d = ST_DONE;
        end else begin
          state_d  = ST_FETCH;
          en_rom_d = 1'b1;
          adrs_d   = ADR_W'(i_nxt_c - IDX_W'(1));
        end
      end
      ST_DONE: begin
        if (!rdy_q) begin
          rdy_d   = 1'b1;
          z_out_d = z_q;
          x_out_d = x_q;
        end else if (ACK_FSM) begin
          rdy_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      i_q      <= IDX_W'(1);
      rep_q    <= 1'b0;
      en_rom_q <= 1'b0;
      adrs_q   <= '0;
      z_out_q  <= '0;
      x_out_q  <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      i_q      <= i_d;
      rep_q    <= rep_d;
      en_rom_q <= en_rom_d;
      adrs_q   <= adrs_d;
      z_out_q  <= z_out_d;
      x_out_q  <= x_out_d;
      rdy_q    <= rdy_d;
    end
  end

  assign EN_ROM1 = en_rom_q;
  assign ADRS    = adrs_q;
  assign Z_OUT   = z_out_q;
  assign X_OUT   = x_out_q;
  assign RDY     = rdy_q;

endmodule

// File: doc/hyp_cordic_vectoring_unit.md
# hyp_cordic_vectoring_unit

Iterative hyperbolic CORDIC engine in vectoring mode for the natural-logarithm datapath. It computes Z = atanh(Y/X) and sits directly downstream of the arctanh constant ROM (LUT_Z). It drives that ROM's enable and address and consumes its data word one iteration at a time. Upstream pre-processing supplies X = w+1 and Y = w−1; the downstream stage forms ln(w) = 2·Z.

## Interface
- WIDTH, 32: datapath width of X, Y, Z and the ROM word; all values are signed Q2.(WIDTH−2).
- ITER, 24: number of distinct iteration indices i = 1..ITER; legal range 13..32.
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset; asynchronous and active-high. Clears the FSM and all outputs.
- BEG_FSM  in  1  start pulse; sampled only in IDLE.
- ACK_FSM  in  1  result consumed; releases DONE.
- X_IN  in  WIDTH  initial X, captured when a start is accepted.
- Y_IN  in  WIDTH  initial Y, captured when a start is accepted.
- O_D  in  WIDTH  ROM data; atanh(2^−(ADRS+1)) in Q2.(WIDTH−2), valid one cycle after EN_ROM1=1.
- EN_ROM1  out  1  ROM read enable.
- ADRS  out  5  ROM address = i−1.
- Z_OUT  out  WIDTH  accumulated angle.
- X_OUT  out  WIDTH  final X (carries CORDIC gain, uncorrected).
- RDY  out  1  result valid; held high until ACK_FSM.

## Operation
- States: IDLE → LOAD → FETCH ⇄ ITER → DONE → IDLE.
- IDLE:
  - BEG_FSM=1 → LOAD.
  - X_IN and Y_IN are registered into x and y; z is cleared to 0; i is set to 1; the repeat flag is cleared.
- LOAD: one cycle, then FETCH.
- FETCH:
  - EN_ROM1=1, ADRS=i−1.
  - Next state ITER.
- ITER (O_D now valid):
  - σ = +1 if y<0, else −1.
  - x ← x + σ·(y>>>i).
  - y ← y + σ·(x>>>i).
  - z ← z − σ·O_D.
  - All three updates use the old x and y.
- Step advance after ITER:
  - If i∈{4,13} and the repeat flag is clear: set the flag, keep i.
  - Otherwise clear the flag and increment i.
  - If i was ITER with no repeat pending → DONE; else → FETCH.
- Arithmetic rules:
  - `>>>` is an arithmetic shift.
  - Adds and subtracts are two's complement and wrap modulo 2^WIDTH, with no saturation.
  - Convergence requires |Y/X| < 0.80. Out-of-range inputs are not flagged.
- DONE:
  - Z_OUT and X_OUT are registered; RDY=1.
  - Stays in DONE until ACK_FSM=1, then → IDLE.
  - An ACK_FSM that arrives in the same cycle RDY first rises is honoured on the next edge.
- Start handling: BEG_FSM outside IDLE is ignored; it is not queued.
- Address sequence (ITER=24): 0,1,2,3,3,4,…,12,12,13,…,23, for 26 reads in total.

## Timing
- Reset values: EN_ROM1=0, ADRS=0, Z_OUT=0, X_OUT=0, RDY=0, state IDLE.
- RST asserted at any point, including mid-iteration, forces the same values asynchronously. After reset the unit needs a new BEG_FSM.
- Start-to-result latency:
  - Let R = 2 repeats.
  - Total latency is 1 (LOAD) + 2·(ITER+R) + 1 cycles from the BEG_FSM edge to RDY=1.
  - For ITER=24 this is 54 cycles.
- EN_ROM1 is high only in FETCH cycles. ADRS holds its last value outside FETCH.
- Back-to-back operation: the earliest next start is the cycle after ACK_FSM is sampled, when the FSM is back in IDLE.

## Structure
- Shared package (lut_cordic_pkg):
  - state enum;
  - repeat indices 4 and 13;
  - WIDTH default;
  - Q-format fraction-bit constant.
- Sub-module hyp_cordic_stage: combinational shift/add/sub of x, y and z given σ, i and O_D.
- The top level holds the FSM, the iteration counter, the repeat flag and the output registers.
- The bench instantiates LUT_Z as the ROM model.

## Test plan
- Nominal: X_IN=0x40000000 (1.0), Y_IN=0x20000000 (0.5), then BEG_FSM pulse → RDY at cycle 54; Z_OUT within ±0x400 of 0x2327D4F6.
- Address trace: during the same run, EN_ROM1 pulses exactly 26 times; the ADRS sequence is 0,1,2,3,3,4,…,12,12,13,…,23.
- Negative input: X_IN=0x40000000, Y_IN=0xE0000000 (−0.5) → Z_OUT within ±0x400 of 0xDCD82B0A.
- Handshake:
  - Hold ACK_FSM=0 for 20 cycles after DONE → RDY and Z_OUT stay stable.
  - Pulse ACK_FSM → RDY=0 the next cycle.
  - A BEG_FSM issued mid-run is ignored: only one RDY occurs and the result is unchanged.
- Reset mid-operation: assert RST at cycle 20 of a run → EN_ROM1, ADRS, RDY, Z_OUT and X_OUT are 0 immediately (asynchronously); a fresh start then completes correctly.
- ITER=13 build: latency is 1+2·15+1 = 32 cycles; ADRS sequence ends …,11,12,12.
